pulse_monitor: RTL and testbench
================================

Name: pulse_monitor

Overview:
Downstream consumer of the pulse-generator output (Sign). Once armed with an expected pulse count, it synchronises the incoming pulse train and counts its rising edges. It measures the period between edges and flags completion, timeout (stalled generator) and overrun (extra pulses). It sits between the pulse generator and the motion/control logic that issues the next command.

Parameters:
CNT_W, 10, width of expected/actual pulse count (matches PulseNum width)
PER_W, 16, width of period measurement and timeout timer
TIMEOUT, 1000, clk cycles without a rising edge before timeout while busy (must be < 2^PER_W)
SYNC_STAGES, 2, synchroniser flops on pulse_in (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle arm request; latches exp_num
abort  in  1  single-cycle cancel of measurement in progress
exp_num  in  CNT_W  expected number of pulses
pulse_in  in  1  pulse train from pulse generator (asynchronous to clk)
count  out  CNT_W  rising edges counted since last start
period  out  PER_W  clk cycles between the last two counted edges
busy  out  1  measurement in progress
done  out  1  expected count reached (level)
timeout_err  out  1  no edge within TIMEOUT cycles while busy (sticky)
overrun_err  out  1  edge seen while in DONE (sticky)

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, synchroniser flops 0, timer 0.
- Edge detect: SYNC_STAGES-flop synchroniser plus one history flop. edge = sync_out & ~hist. count updates on the clk edge where edge=1. With SYNC_STAGES=2, a pulse_in rise first sampled at clk edge k updates count at edge k+2 (visible after k+2).
- States: IDLE, WAIT_FIRST, COUNTING, DONE, TMO.
- IDLE: busy=0. start=1 -> latch exp_num; clear count, period, timer, done, timeout_err, overrun_err.
  - exp_num==0 -> DONE (done=1 next cycle).
  - Otherwise -> WAIT_FIRST (busy=1 next cycle).
- WAIT_FIRST: on edge: count=1, timer=0, period unchanged (0).
  - If exp==1 -> DONE, else -> COUNTING.
- COUNTING: timer increments every cycle (saturating at all-ones). On edge: count+1, period=timer+1, timer=0. If count+1==exp -> DONE.
- Timeout, WAIT_FIRST/COUNTING: timer==TIMEOUT-1 with no edge that cycle -> TMO; timeout_err=1, busy=0.
- Simultaneous events: edge and timeout in the same cycle -> edge wins.
- DONE: done=1, busy=0; count frozen. Any edge sets overrun_err (sticky); count does not change.
- TMO: busy=0, timeout_err held; count frozen.
- start in DONE/TMO/IDLE: re-arms as from IDLE. start while busy: ignored.
- abort in any state: -> IDLE next cycle; busy=0, done=0; count/period/error flags retained. abort and start in the same cycle: abort wins.
- Count never wraps: exp_num <= 2^CNT_W-1 guarantees DONE before wrap.

Decomposition:
- Shared package pulse_pkg:
  - FSM state typedef (IDLE, WAIT_FIRST, COUNTING, DONE, TMO)
  - CNT_W/PER_W default constants
  - default TIMEOUT constant, shared with the generator's divider setting
- One sub-module: pulse_edge_sync (synchroniser + rising-edge detector, parameter SYNC_STAGES, ports clk, rst, d_in, edge).

Test Plan:
- exp_num=5, start; 5 pulses each 100 clk high/100 clk low -> done=1 two clk after 5th rise sampled; count=5; period=200; busy=0; no errors.
- exp_num=0, start -> done=1 next cycle; count=0; busy never 1.
- TIMEOUT=1000, exp_num=3; 2 pulses then pulse_in held 0 -> timeout_err=1 exactly 1000 cycles after 2nd edge counted; count=2; busy=0; done=0.
- exp_num=2; 4 pulses -> done after 2nd edge; overrun_err=1 on 3rd edge; count stays 2.
- exp_num=10; after 3 edges, start pulse while busy -> ignored (count continues to 4 on next edge). Then abort and start in the same cycle -> IDLE, busy=0, count=4 retained.
- exp_num=10; rst=0 mid-count (asynchronous, between clk edges) -> all outputs 0 immediately. Release rst, start with exp_num=1 plus one pulse -> done=1, count=1.

Source files
------------

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and defaults for the pulse monitor slice.
// Default widths track the pulse generator's PulseNum and divider setup.
package pulse_pkg;

    localparam int CNT_W_DEF       = 10;
    localparam int PER_W_DEF       = 16;
    localparam int TIMEOUT_DEF     = 1000;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        COUNTING,
        DONE,
        TMO
    } state_t;

endpackage

// File: rtl/pulse_edge_sync.sv
// pulse_edge_sync: multi-flop synchroniser for an async input followed
// by a history flop, producing a one-cycle strobe on each rising edge.
module pulse_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // shift the async input through the sync chain, keep last output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/pulse_monitor.sv
// pulse_monitor: counts synchronised rising edges against an armed
// target, measures edge period, flags done, timeout and overrun.
module pulse_monitor
    import pulse_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PER_W       = PER_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] exp_num,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] count,
    output logic [PER_W-1:0] period,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic             overrun_err
);

    localparam logic [PER_W-1:0] TMO_LIM = PER_W'(TIMEOUT - 1);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic [CNT_W-1:0] exp_q, exp_n;
    logic [PER_W-1:0] per_q, per_n;
    logic [PER_W-1:0] tmr_q, tmr_n, tmr_inc;
    logic             tmo_q, tmo_n;
    logic             ovr_q, ovr_n;
    logic             rise;

    pulse_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_in(pulse_in),
        .rise(rise)
    );

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            per_q   <= '0;
            tmr_q   <= '0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            exp_q   <= exp_n;
            per_q   <= per_n;
            tmr_q   <= tmr_n;
            tmo_q   <= tmo_n;
            ovr_q   <= ovr_n;
        end
    end

    // next state: abort first, then re-arm, edge beats timeout
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        exp_n   = exp_q;
        per_n   = per_q;
        tmr_n   = tmr_q;
        tmo_n   = tmo_q;
        ovr_n   = ovr_q;
        cnt_inc = cnt_q + 1'b1;
        tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE, TMO: begin
                    if (start) begin
                        exp_n   = exp_num;
                        cnt_n   = '0;
                        per_n   = '0;
                        tmr_n   = '0;
                        tmo_n   = 1'b0;
                        ovr_n   = 1'b0;
                        state_n = (exp_num == '0) ? DONE : WAIT_FIRST;
                    end else if (state_q == DONE && rise) begin
                        ovr_n = 1'b1;
                    end
                end
                WAIT_FIRST: begin
                    if (rise) begin
                        cnt_n   = CNT_W'(1);
                        tmr_n   = '0;
                        state_n = (exp_q == CNT_W'(1)) ? DONE : COUNTING;
                    end else if (tmr_q == TMO_LIM) begin
                        tmo_n   = 1'b1;
                        state_n = TMO;
                    end else begin
                        tmr_n = tmr_inc;
                    end
                end
                COUNTING: begin
                    if (rise) begin
                        cnt_n = cnt_inc;
                        per_n = tmr_inc;
                        tmr_n = '0;
                        if (cnt_inc == exp_q) begin
                            state_n = DONE;
                        end
                    end else if (tmr_q == TMO_LIM) begin
                        tmo_n   = 1'b1;
                        state_n = TMO;
                    end else begin
                        tmr_n = tmr_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign count       = cnt_q;
    assign period      = per_q;
    assign busy        = (state_q == WAIT_FIRST) || (state_q == COUNTING);
    assign done        = (state_q == DONE);
    assign timeout_err = tmo_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: scenario tasks plus randomized pulse trains checked
// against expectations derived from recorded edge sample times.
module tb_pulse_monitor;

    localparam int CW  = 10;
    localparam int PW  = 16;
    localparam int TMO = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pulse_in = 1'b0;
    logic [CW-1:0] exp_num = '0;
    logic [CW-1:0] count;
    logic [PW-1:0] period;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic          overrun_err;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;

    pulse_monitor #(
        .CNT_W      (CW),
        .PER_W      (PW),
        .TIMEOUT    (TMO),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .exp_num    (exp_num),
        .pulse_in   (pulse_in),
        .count      (count),
        .period     (period),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input int n);
        @(negedge clk);
        exp_num = CW'(n);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // s = clk edge number at which the rise is first sampled
    task automatic pulse(input int h, input int l, output int s);
        @(negedge clk);
        pulse_in = 1'b1;
        s = cyc + 1;
        repeat (h) @(negedge clk);
        pulse_in = 1'b0;
        repeat (l - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        idle(3);
        vec++; if (count !== '0) begin errs++;
            $display("FAIL rst_count got %0d want 0", count); end
        vec++; if (period !== '0) begin errs++;
            $display("FAIL rst_period got %0d want 0", period); end
        vec++; if (busy !== 1'b0) begin errs++;
            $display("FAIL rst_busy got %b want 0", busy); end
        vec++; if (done !== 1'b0) begin errs++;
            $display("FAIL rst_done got %b want 0", done); end
        vec++; if (timeout_err !== 1'b0) begin errs++;
            $display("FAIL rst_tmo got %b want 0", timeout_err); end
        vec++; if (overrun_err !== 1'b0) begin errs++;
            $display("FAIL rst_ovr got %b want 0", overrun_err); end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int s;
        arm(5);
        vec++; if (busy !== 1'b1) begin errs++;
            $display("FAIL basic_busy got %b want 1", busy); end
        for (int i = 0; i < 4; i++) pulse(100, 100, s);
        @(negedge clk);
        pulse_in = 1'b1;
        s = cyc + 1;
        while (cyc < s + 1) @(negedge clk);
        vec++; if (done !== 1'b0) begin errs++;
            $display("FAIL basic_done_early got %b want 0", done); end
        @(negedge clk);
        vec++; if (done !== 1'b1) begin errs++;
            $display("FAIL basic_done_lat got %b want 1", done); end
        idle(98);
        pulse_in = 1'b0;
        idle(5);
        vec++; if (count !== CW'(5)) begin errs++;
            $display("FAIL basic_count got %0d want 5", count); end
        vec++; if (period !== PW'(200)) begin errs++;
            $display("FAIL basic_period got %0d want 200", period); end
        vec++; if (busy !== 1'b0) begin errs++;
            $display("FAIL basic_busy_end got %b want 0", busy); end
        vec++; if ({timeout_err, overrun_err} !== 2'b00) begin errs++;
            $display("FAIL basic_errs got %b%b want 00",
                     timeout_err, overrun_err); end
    endtask

    task automatic test_zero();
        logic seen_busy;
        seen_busy = 1'b0;
        @(negedge clk);
        exp_num = '0;
        start   = 1'b1;
        seen_busy |= busy;
        @(negedge clk);
        start   = 1'b0;
        seen_busy |= busy;
        vec++; if (done !== 1'b1) begin errs++;
            $display("FAIL zero_done got %b want 1", done); end
        vec++; if (count !== '0) begin errs++;
            $display("FAIL zero_count got %0d want 0", count); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        vec++; if (seen_busy !== 1'b0) begin errs++;
            $display("FAIL zero_busy got %b want 0", seen_busy); end
        vec++; if (period !== '0) begin errs++;
            $display("FAIL zero_period got %0d want 0", period); end
    endtask

    task automatic test_timeout();
        int s;
        int t;
        arm(3);
        pulse(10, 10, s);
        pulse(10, 10, s);
        t = -1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                t = cyc;
                break;
            end
        end
        vec++; if (t != s + 2 + TMO) begin errs++;
            $display("FAIL tmo_time got %0d want %0d", t, s + 2 + TMO); end
        vec++; if (count !== CW'(2)) begin errs++;
            $display("FAIL tmo_count got %0d want 2", count); end
        vec++; if (busy !== 1'b0) begin errs++;
            $display("FAIL tmo_busy got %b want 0", busy); end
        vec++; if (done !== 1'b0) begin errs++;
            $display("FAIL tmo_done got %b want 0", done); end
    endtask

    task automatic test_overrun();
        int s;
        arm(2);
        pulse(5, 5, s);
        pulse(5, 5, s);
        idle(3);
        vec++; if (done !== 1'b1) begin errs++;
            $display("FAIL ovr_done got %b want 1", done); end
        vec++; if (overrun_err !== 1'b0) begin errs++;
            $display("FAIL ovr_early got %b want 0", overrun_err); end
        pulse(5, 5, s);
        idle(3);
        vec++; if (overrun_err !== 1'b1) begin errs++;
            $display("FAIL ovr_flag got %b want 1", overrun_err); end
        vec++; if (count !== CW'(2)) begin errs++;
            $display("FAIL ovr_count got %0d want 2", count); end
        pulse(5, 5, s);
        idle(3);
        vec++; if (count !== CW'(2)) begin errs++;
            $display("FAIL ovr_count4 got %0d want 2", count); end
        vec++; if (period !== PW'(10)) begin errs++;
            $display("FAIL ovr_period got %0d want 10", period); end
    endtask

    task automatic test_back_to_back();
        int s;
        arm(10);
        for (int i = 0; i < 3; i++) pulse(6, 6, s);
        @(negedge clk);
        exp_num = CW'(1);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pulse(6, 6, s);
        idle(3);
        vec++; if (count !== CW'(4)) begin errs++;
            $display("FAIL b2b_count got %0d want 4", count); end
        vec++; if (busy !== 1'b1) begin errs++;
            $display("FAIL b2b_busy got %b want 1", busy); end
        @(negedge clk);
        abort   = 1'b1;
        start   = 1'b1;
        exp_num = CW'(5);
        @(negedge clk);
        abort   = 1'b0;
        start   = 1'b0;
        vec++; if (busy !== 1'b0) begin errs++;
            $display("FAIL abort_busy got %b want 0", busy); end
        vec++; if (done !== 1'b0) begin errs++;
            $display("FAIL abort_done got %b want 0", done); end
        idle(3);
        vec++; if (count !== CW'(4)) begin errs++;
            $display("FAIL abort_count got %0d want 4", count); end
        vec++; if (busy !== 1'b0) begin errs++;
            $display("FAIL abort_idle got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int s;
        arm(10);
        pulse(4, 4, s);
        pulse(4, 4, s);
        idle(3);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        vec++; if (count !== '0) begin errs++;
            $display("FAIL arst_count got %0d want 0", count); end
        vec++; if (period !== '0) begin errs++;
            $display("FAIL arst_period got %0d want 0", period); end
        vec++; if ({busy, done, timeout_err, overrun_err} !== 4'b0) begin
            errs++;
            $display("FAIL arst_flags got %b%b%b%b want 0000",
                     busy, done, timeout_err, overrun_err); end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        arm(1);
        pulse(5, 5, s);
        idle(3);
        vec++; if (done !== 1'b1) begin errs++;
            $display("FAIL arst_done got %b want 1", done); end
        vec++; if (count !== CW'(1)) begin errs++;
            $display("FAIL arst_cnt1 got %0d want 1", count); end
    endtask

    task automatic test_random();
        int e, n, c, s, h, l;
        int rises[$];
        logic [PW-1:0] ep;
        for (int it = 0; it < 10; it++) begin
            rises.delete();
            e = $urandom_range(1, 8);
            n = $urandom_range(1, 10);
            arm(e);
            for (int k = 0; k < n; k++) begin
                h = $urandom_range(1, 20);
                l = $urandom_range(1, 20);
                pulse(h, l, s);
                rises.push_back(s);
            end
            idle(4);
            c  = (n < e) ? n : e;
            ep = (c >= 2) ? PW'(rises[c-1] - rises[c-2]) : '0;
            vec++; if (count !== CW'(c)) begin errs++;
                $display("FAIL rnd%0d_count got %0d want %0d",
                         it, count, c); end
            vec++; if (period !== ep) begin errs++;
                $display("FAIL rnd%0d_period got %0d want %0d",
                         it, period, ep); end
            vec++; if (done !== (n >= e)) begin errs++;
                $display("FAIL rnd%0d_done got %b want %b",
                         it, done, n >= e); end
            vec++; if (busy !== (n < e)) begin errs++;
                $display("FAIL rnd%0d_busy got %b want %b",
                         it, busy, n < e); end
            vec++; if (overrun_err !== (n > e)) begin errs++;
                $display("FAIL rnd%0d_ovr got %b want %b",
                         it, overrun_err, n > e); end
            vec++; if (timeout_err !== 1'b0) begin errs++;
                $display("FAIL rnd%0d_tmo got %b want 0",
                         it, timeout_err); end
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            idle(3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
